// File: rtl/audio_dac_feeder.sv
// Stereo two-source mixer that paces samples at a fixed tick, applies a pop-free
// gain ramp, and drives offset-binary DAC codes that only change on sample_strobe.
module audio_dac_feeder #(
    parameter int SAMPLE_DIV = 1024,
    parameter int RAMP_STEP  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [15:0] a_l,
    input  logic [15:0] a_r,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [15:0] b_l,
    input  logic [15:0] b_r,
    output logic [15:0] d_l,
    output logic [15:0] d_r,
    output logic        sample_strobe,
    output logic        muted,
    output logic [1:0]  underrun,
    input  logic        clear_underrun,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

    localparam int                CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [9:0]        STEP     = 10'(RAMP_STEP);
    localparam logic [9:0]        FULL     = 10'd256;

    function automatic logic [15:0] sat_add(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        s = {x[15], x} + {y[15], y};
        if (s[16] != s[15]) sat_add = s[16] ? 16'h8000 : 16'h7FFF;
        else                sat_add = s[15:0];
    endfunction

    // Signed sample times unsigned gain, >>> 8 so 256 is unity and rounding is floor.
    function automatic logic [15:0] apply_gain(input logic [15:0] s, input logic [8:0] g);
        logic signed [25:0] p;
        p = $signed({{10{s[15]}}, s}) * $signed({17'd0, g});
        apply_gain = 16'(p >>> 8);
    endfunction

    logic [CNT_W-1:0] cnt;
    logic             tick;
    state_t           state, state_nxt, up_tgt, dn_tgt;
    logic [8:0]       gain, gain_up, gain_dn, gain_q;
    logic [9:0]       gain_w, up_sum;
    logic             muted_d;
    logic [1:0]       und_set;
    logic [15:0]      hold_a_l, hold_a_r, hold_b_l, hold_b_r;
    logic [15:0]      a_l_eff, a_r_eff, b_l_eff, b_r_eff;
    logic [15:0]      sat_l_q, sat_r_q, p_l_q, p_r_q;
    logic             v1, v2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CNT_LAST);
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Handshake: ready is the tick pulse itself, regardless of valid or state; a
    // transfer is valid && ready in the same cycle, so each source moves at most
    // one sample per tick and a source that is not valid on the tick is skipped.
    assign a_ready   = tick;
    assign b_ready   = tick;
    assign state_dbg = state;

    assign gain_w  = {1'b0, gain};
    assign up_sum  = gain_w + STEP;
    assign gain_up = (up_sum >= FULL) ? 9'd256 : up_sum[8:0];
    assign gain_dn = (gain_w <= STEP) ? 9'd0 : 9'(gain_w - STEP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // An enable flip on a tick cycle already steers that tick's ramp direction.
    always_comb begin
        up_tgt    = (tick && gain_up == 9'd256) ? RUN : RAMP_UP;
        dn_tgt    = (tick && gain_dn == 9'd0) ? IDLE : RAMP_DOWN;
        state_nxt = state;
        case (state)
            IDLE:      if (enable) state_nxt = up_tgt;
            RAMP_UP:   state_nxt = enable ? up_tgt : dn_tgt;
            RUN:       if (!enable) state_nxt = dn_tgt;
            RAMP_DOWN: state_nxt = enable ? up_tgt : dn_tgt;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        muted_d = (state == IDLE);
        und_set = 2'b00;
        if (tick && state != IDLE) begin
            und_set[0] = ~a_valid;
            und_set[1] = ~b_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gain     <= 9'd0;
            muted    <= 1'b1;
            underrun <= 2'b00;
        end else begin
            muted    <= muted_d;
            underrun <= (underrun & ~{2{clear_underrun}}) | und_set;
            if (tick) begin
                if (enable && state != RUN)       gain <= gain_up;
                else if (!enable && state != IDLE) gain <= gain_dn;
            end
        end
    end

    assign a_l_eff = a_valid ? a_l : hold_a_l;
    assign a_r_eff = a_valid ? a_r : hold_a_r;
    assign b_l_eff = b_valid ? b_l : hold_b_l;
    assign b_r_eff = b_valid ? b_r : hold_b_r;

    // Three-stage sample path: sum/saturate, gain, offset-binary output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_a_l      <= '0;
            hold_a_r      <= '0;
            hold_b_l      <= '0;
            hold_b_r      <= '0;
            sat_l_q       <= '0;
            sat_r_q       <= '0;
            gain_q        <= '0;
            p_l_q         <= '0;
            p_r_q         <= '0;
            v1            <= 1'b0;
            v2            <= 1'b0;
            sample_strobe <= 1'b0;
            d_l           <= 16'h8000;
            d_r           <= 16'h8000;
        end else begin
            v1            <= tick;
            v2            <= v1;
            sample_strobe <= v2;
            if (tick) begin
                hold_a_l <= a_l_eff;
                hold_a_r <= a_r_eff;
                hold_b_l <= b_l_eff;
                hold_b_r <= b_r_eff;
                sat_l_q  <= sat_add(a_l_eff, b_l_eff);
                sat_r_q  <= sat_add(a_r_eff, b_r_eff);
                gain_q   <= gain;
            end
            if (v1) begin
                p_l_q <= apply_gain(sat_l_q, gain_q);
                p_r_q <= apply_gain(sat_r_q, gain_q);
            end
            if (v2) begin
                d_l <= p_l_q ^ 16'h8000;
                d_r <= p_r_q ^ 16'h8000;
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_feeder.sv
// Bench for audio_dac_feeder: a tick/gain model feeds an expected-sample queue that
// is drained on every sample_strobe; scenario tasks add targeted inline checks.
module tb_audio_dac_feeder;

    localparam int DIV  = 16;
    localparam int STEP = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0, clear_underrun = 1'b0;
    logic [15:0] a_l = '0, a_r = '0, b_l = '0, b_r = '0;
    logic        a_ready, b_ready, sample_strobe, muted;
    logic [15:0] d_l, d_r;
    logic [1:0]  underrun, state_dbg;

    int          n_vec = 0;
    int          n_miss = 0;
    int          since;
    logic [31:0] exp_q[$];
    logic [31:0] last_d, mon_exp;
    logic [15:0] m_ha_l, m_ha_r, m_hb_l, m_hb_r;
    int          m_gain;

    audio_dac_feeder #(.SAMPLE_DIV(DIV), .RAMP_STEP(STEP)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .a_valid(a_valid), .a_ready(a_ready), .a_l(a_l), .a_r(a_r),
        .b_valid(b_valid), .b_ready(b_ready), .b_l(b_l), .b_r(b_r),
        .d_l(d_l), .d_r(d_r), .sample_strobe(sample_strobe), .muted(muted),
        .underrun(underrun), .clear_underrun(clear_underrun), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset-relative cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) since <= 0;
        else          since <= since + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] mix(input logic [15:0] a, input logic [15:0] b, input int g);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        s = (s * g) >>> 8;
        mix = 16'(s) ^ 16'h8000;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            m_gain = 0;
            m_ha_l = '0; m_ha_r = '0; m_hb_l = '0; m_hb_r = '0;
            exp_q.delete();
        end else if (since > 0 && since % DIV == 0) begin
            if (a_valid) begin m_ha_l = a_l; m_ha_r = a_r; end
            if (b_valid) begin m_hb_l = b_l; m_hb_r = b_r; end
            exp_q.push_back({mix(m_ha_l, m_hb_l, m_gain), mix(m_ha_r, m_hb_r, m_gain)});
            if (enable) m_gain = (m_gain + STEP > 256) ? 256 : m_gain + STEP;
            else        m_gain = (m_gain < STEP) ? 0 : m_gain - STEP;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            last_d = 32'h8000_8000;
        end else if (sample_strobe === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL sample_extra: got %h expected no sample", {d_l, d_r});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({d_l, d_r} !== mon_exp) begin
                    n_miss++;
                    $display("FAIL sample_value: got %h expected %h (since=%0d)", {d_l, d_r}, mon_exp, since);
                end
            end
            last_d = {d_l, d_r};
        end else begin
            n_vec++;
            if ({d_l, d_r} !== last_d) begin
                n_miss++;
                $display("FAIL hold_stable: got %h expected %h (since=%0d)", {d_l, d_r}, last_d, since);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_phase(input int p);
        for (int i = 0; i < 2 * DIV; i++) begin
            step();
            if (since > 0 && since % DIV == p) break;
        end
    endtask

    task automatic send(input logic av, input logic [15:0] al, input logic [15:0] ar,
                        input logic bv, input logic [15:0] bl, input logic [15:0] br,
                        input logic clr);
        go_phase(0);
        a_valid = av; a_l = al; a_r = ar;
        b_valid = bv; b_l = bl; b_r = br;
        clear_underrun = clr;
        step();
        a_valid = 1'b0; b_valid = 1'b0; clear_underrun = 1'b0;
    endtask

    task automatic wait_strobe(output logic [15:0] l, output logic [15:0] r, output bit ok, output int ph);
        ok = 1'b0; l = '0; r = '0; ph = -1;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            if (sample_strobe === 1'b1) begin
                l = d_l; r = d_r; ph = since % DIV; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_clear();
        step();
        clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({d_l, d_r} !== 32'h8000_8000) begin n_miss++; $display("FAIL reset_d: got %h expected 80008000", {d_l, d_r}); end
        n_vec++;
        if ({sample_strobe, a_ready, b_ready, muted, underrun} !== 6'b000100) begin
            n_miss++; $display("FAIL reset_ctl: got %b expected 000100", {sample_strobe, a_ready, b_ready, muted, underrun});
        end
        reset_n = 1'b1;
        n = -1;
        for (int i = 1; i <= 3 * DIV; i++) begin
            step();
            if (a_ready === 1'b1) begin n = i; break; end
        end
        n_vec++;
        if (n != DIV) begin n_miss++; $display("FAIL first_tick: got %0d cycles expected %0d", n, DIV); end
    endtask

    task automatic test_ramp_up();
        logic [15:0] tab [5];
        logic [15:0] l, r;
        bit ok;
        int ph;
        tab = '{16'h8000, 16'h9000, 16'hA000, 16'hB000, 16'hC000};
        a_valid = 1'b1; a_l = 16'h4000; a_r = 16'h4000;
        b_valid = 1'b1; b_l = 16'h0000; b_r = 16'h0000;
        go_phase(4);
        enable = 1'b1;
        step();
        n_vec++;
        if (muted !== 1'b1) begin n_miss++; $display("FAIL muted_lag: got %b expected 1", muted); end
        step();
        n_vec++;
        if (muted !== 1'b0) begin n_miss++; $display("FAIL muted_fall: got %b expected 0", muted); end
        for (int k = 0; k < 5; k++) begin
            wait_strobe(l, r, ok, ph);
            n_vec++;
            if (!ok || l !== tab[k]) begin n_miss++; $display("FAIL ramp_up[%0d]: got %h ok=%0d expected %h", k, l, ok, tab[k]); end
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_unity_mix();
        logic [15:0] l, r;
        bit ok;
        int ph;
        send(1'b1, 16'h1000, 16'hF000, 1'b1, 16'h0100, 16'h0000, 1'b0);
        wait_strobe(l, r, ok, ph);
        n_vec++;
        if (!ok || {l, r} !== 32'h9100_7000) begin n_miss++; $display("FAIL unity_mix: got %h ok=%0d expected 91007000", {l, r}, ok); end
        n_vec++;
        if (ph != 3) begin n_miss++; $display("FAIL unity_latency: got phase %0d expected 3", ph); end
        @(negedge clk);
        n_vec++;
        if (sample_strobe !== 1'b0) begin n_miss++; $display("FAIL strobe_width: got %b expected 0", sample_strobe); end
    endtask

    task automatic test_saturation();
        logic [15:0] sa [5], sb [5], se [5];
        logic [15:0] l, r;
        bit ok;
        int ph;
        sa = '{16'h7000, 16'h9000, 16'h7FFF, 16'h8000, 16'h4000};
        sb = '{16'h7000, 16'h9000, 16'h0001, 16'hFFFF, 16'h3FFF};
        se = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        for (int k = 0; k < 5; k++) begin
            send(1'b1, sa[k], sa[k], 1'b1, sb[k], sb[k], 1'b0);
            wait_strobe(l, r, ok, ph);
            n_vec++;
            if (!ok || l !== se[k] || r !== se[k]) begin
                n_miss++; $display("FAIL saturate[%0d]: got %h/%h expected %h", k, l, r, se[k]);
            end
        end
    endtask

    task automatic test_underrun_run();
        logic [15:0] l, r;
        bit ok;
        int ph;
        pulse_clear();
        n_vec++;
        if (underrun !== 2'b00) begin n_miss++; $display("FAIL und_clear: got %b expected 00", underrun); end
        send(1'b1, 16'h0200, 16'h0300, 1'b1, 16'h0000, 16'h0000, 1'b0);
        wait_strobe(l, r, ok, ph);
        n_vec++;
        if (!ok || {l, r} !== 32'h8200_8300) begin n_miss++; $display("FAIL und_base: got %h expected 82008300", {l, r}); end
        send(1'b0, 16'h5555, 16'h5555, 1'b1, 16'h0010, 16'h0020, 1'b0);
        wait_strobe(l, r, ok, ph);
        n_vec++;
        if (!ok || {l, r} !== 32'h8210_8320) begin n_miss++; $display("FAIL und_reuse_a: got %h expected 82108320", {l, r}); end
        n_vec++;
        if (underrun !== 2'b01) begin n_miss++; $display("FAIL und_set_a: got %b expected 01", underrun); end
        send(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h6666, 16'h6666, 1'b1);
        wait_strobe(l, r, ok, ph);
        n_vec++;
        if (underrun !== 2'b10) begin n_miss++; $display("FAIL und_set_wins: got %b expected 10", underrun); end
        n_vec++;
        if (!ok || {l, r} !== 32'h8010_8020) begin n_miss++; $display("FAIL und_reuse_b: got %h expected 80108020", {l, r}); end
    endtask

    task automatic test_handshake();
        int ph, xfers;
        pulse_clear();
        xfers = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            step();
            ph = since % DIV;
            a_valid = 1'b1; a_l = 16'(i * 273); a_r = ~a_l;
            b_valid = (ph != 0); b_l = 16'h7777; b_r = 16'h7777;
            n_vec++;
            if (a_ready !== (ph == 0) || b_ready !== (ph == 0)) begin
                n_miss++; $display("FAIL ready_phase: got %b%b expected %b at phase %0d", a_ready, b_ready, ph == 0, ph);
            end
            if (a_valid && a_ready) xfers++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        n_vec++;
        if (xfers != 2) begin n_miss++; $display("FAIL xfer_count: got %0d expected 2", xfers); end
        step();
        n_vec++;
        if (underrun !== 2'b10) begin n_miss++; $display("FAIL offtick_b: got %b expected 10", underrun); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        send(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        reset_n = 1'b0;
        enable = 1'b0;
        #1;
        n_vec++;
        if ({d_l, d_r} !== 32'h8000_8000 || muted !== 1'b1 || underrun !== 2'b00 || sample_strobe !== 1'b0) begin
            n_miss++; $display("FAIL reset_mid: got d=%h muted=%b und=%b strobe=%b expected 80008000/1/00/0",
                               {d_l, d_r}, muted, underrun, sample_strobe);
        end
        step();
        step();
        reset_n = 1'b1;
        n = -1;
        for (int i = 1; i <= 3 * DIV; i++) begin
            step();
            if (a_ready === 1'b1) begin n = i; break; end
        end
        n_vec++;
        if (n != DIV) begin n_miss++; $display("FAIL rerun_tick: got %0d cycles expected %0d", n, DIV); end
    endtask

    task automatic test_underrun_idle();
        go_phase(2);
        go_phase(2);
        n_vec++;
        if (underrun !== 2'b00 || muted !== 1'b1) begin
            n_miss++; $display("FAIL idle_underrun: got und=%b muted=%b expected 00/1", underrun, muted);
        end
    endtask

    task automatic test_ramp_reverse();
        logic [15:0] up_tab [2], dn_tab [3];
        logic [15:0] l, r;
        bit ok;
        int ph;
        up_tab = '{16'h8000, 16'h9000};
        dn_tab = '{16'hA000, 16'h9000, 16'h8000};
        a_valid = 1'b1; a_l = 16'h4000; a_r = 16'h4000;
        b_valid = 1'b1; b_l = 16'h0000; b_r = 16'h0000;
        go_phase(4);
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_strobe(l, r, ok, ph);
            n_vec++;
            if (!ok || l !== up_tab[k]) begin n_miss++; $display("FAIL rev_up[%0d]: got %h expected %h", k, l, up_tab[k]); end
        end
        step();
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_strobe(l, r, ok, ph);
            n_vec++;
            if (!ok || l !== dn_tab[k]) begin n_miss++; $display("FAIL rev_down[%0d]: got %h expected %h", k, l, dn_tab[k]); end
            if (k < 2) begin
                n_vec++;
                if (muted !== (k == 1)) begin n_miss++; $display("FAIL rev_muted[%0d]: got %b expected %b", k, muted, k == 1); end
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_unity_mix();
        test_saturation();
        test_underrun_run();
        test_handshake();
        test_reset_mid_run();
        test_underrun_idle();
        test_ramp_reverse();
        go_phase(4);
        n_vec++;
        if (exp_q.size() != 0) begin n_miss++; $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        n_miss++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
